// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared constants and Gray/binary helpers for the async FIFO
package afifo_pkg;

  localparam int ADDRSIZE_DFLT = 4;
  localparam int DEPTH         = 2**ADDRSIZE_DFLT;
  // Helpers work on a wide vector so any ADDRSIZE can zero-extend into them;
  // leading zeros do not disturb either conversion.
  localparam int PTR_MAX       = 32;

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// rtl/sync_r2w.sv - multi-flop pointer synchronizer, async active-high reset
module sync_r2w #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Plain flop chain: no logic between stages so metastability can settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-side pointer, full/almost-full, level and overflow
module wptr_full_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wrptr_async,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow,
  input  logic                wclr_ovf
);

  localparam int PW = ADDRSIZE + 1;
  // Inverting the top two Gray bits of the read pointer gives the full point.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDRSIZE - 1);
  localparam logic [PW-1:0] AFULL_TH  = PW'(AFULL_THRESH);

  logic [PW-1:0] wq_rptr;
  logic [PW-1:0] wq_rbin;

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,  wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q,   wovf_d;

  sync_r2w #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync_r2w (
    .clk_i (wclk),
    .rst_i (wrst),
    .d_i   (wrptr_async),
    .q_o   (wq_rptr)
  );

  assign wq_rbin = PW'(gray2bin(PTR_MAX'(wq_rptr)));

  always_comb begin
    wbin_d   = wbin_q + PW'(winc & ~wfull_q);
    wptr_d   = PW'(bin2gray(PTR_MAX'(wbin_d)));
    wfull_d  = (wptr_d == (wq_rptr ^ FULL_MASK));
    wlevel_d = wbin_d - wq_rbin;
    wafull_d = (wlevel_d >= AFULL_TH);
    // A new overflow in the same cycle as a clear keeps the flag set.
    wovf_d   = (winc & wfull_q) | (wovf_q & ~wclr_ovf);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule
